// File: rtl/ram_load_receiver_pkg.sv
// Shared widths, FSM encodings and payload test word for the RAM load receiver.
// Optional watchdog is enabled by defining RAM_LOAD_TIMEOUT_EN.
package ram_load_receiver_pkg;

  localparam int DATA_WIDTH              = 16;
  localparam int PARA_X                  = 2;
  localparam int PARA_Y                  = 2;
  localparam int KERNEL_SIZE_MAX         = 3;
  localparam int PARA_KERNEL             = 2;
  localparam int WRITE_ADDR_WIDTH        = 8;
  localparam int WEIGHT_WRITE_ADDR_WIDTH = 4;

  localparam int FM_W = PARA_X * PARA_Y * DATA_WIDTH;
  localparam int WT_W = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX
                        * PARA_KERNEL * DATA_WIDTH;
  localparam int WA_W = WEIGHT_WRITE_ADDR_WIDTH * PARA_KERNEL;

  localparam logic [DATA_WIDTH-1:0] PAYLOAD_TEST_WORD = 16'h3c00;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_WRITE = 2'd1,
    F_ACK   = 2'd2
  } fm_state_e;

  typedef enum logic [2:0] {
    W_IDLE   = 3'd0,
    W_WRITE  = 3'd1,
    W_ACK    = 3'd2,
    W_REQ    = 3'd3,
    W_RWRITE = 3'd4,
    W_RACK   = 3'd5
  } w_state_e;

  function automatic logic [WA_W-1:0] rep_addr(
    input logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] a
  );
    return {PARA_KERNEL{a}};
  endfunction

endpackage

// File: rtl/ram_load_receiver_if.sv
// Transmitter <-> receiver handshake and RAM write buses.
// slave = receiver side, master = transmitter/compute side.
interface ram_load_receiver_if;
  import ram_load_receiver_pkg::*;

  logic [FM_W-1:0]             init_fm_data;
  logic [WRITE_ADDR_WIDTH-1:0] write_fm_data_addr;
  logic                        init_fm_data_done;
  logic                        init_fm_ram_ready;
  logic [WT_W-1:0]             weight_data;
  logic [WA_W-1:0]             write_weight_data_addr;
  logic                        weight_data_done;
  logic                        init_weight_ram_ready;
  logic                        update_weight_ram;
  logic [WA_W-1:0]             update_weight_ram_addr;
  logic                        fm_ram_we;
  logic [WRITE_ADDR_WIDTH-1:0] fm_ram_addr;
  logic [FM_W-1:0]             fm_ram_wdata;
  logic [PARA_KERNEL-1:0]      weight_ram_we;
  logic [WA_W-1:0]             weight_ram_addr;
  logic [WT_W-1:0]             weight_ram_wdata;
  logic                        weight_refill_req;
  logic                        refill_done;
  logic                        init_loaded;
  logic                        err_timeout;

  modport slave (
    input  init_fm_data, write_fm_data_addr, init_fm_data_done,
    input  weight_data, write_weight_data_addr, weight_data_done,
    input  weight_refill_req,
    output init_fm_ram_ready, init_weight_ram_ready,
    output update_weight_ram, update_weight_ram_addr,
    output fm_ram_we, fm_ram_addr, fm_ram_wdata,
    output weight_ram_we, weight_ram_addr, weight_ram_wdata,
    output refill_done, init_loaded, err_timeout
  );

  modport master (
    output init_fm_data, write_fm_data_addr, init_fm_data_done,
    output weight_data, write_weight_data_addr, weight_data_done,
    output weight_refill_req,
    input  init_fm_ram_ready, init_weight_ram_ready,
    input  update_weight_ram, update_weight_ram_addr,
    input  fm_ram_we, fm_ram_addr, fm_ram_wdata,
    input  weight_ram_we, weight_ram_addr, weight_ram_wdata,
    input  refill_done, init_loaded, err_timeout
  );

endinterface

// File: rtl/ram_load_receiver_rx_channel.sv
// load_rx_channel: capture payload, one-cycle RAM write, hold ack
// until the sender drops done (or the watchdog aborts).
module load_rx_channel
  import ram_load_receiver_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_done,
  input  logic          i_abort,
  input  logic [DW-1:0] i_data,
  input  logic [AW-1:0] i_addr,
  output logic          o_we,
  output logic          o_ack,
  output logic          o_fin,
  output logic [AW-1:0] o_addr,
  output logic [DW-1:0] o_data
);

  fm_state_e     r_state;
  fm_state_e     w_next;
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_addr;
  logic          w_wr;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= F_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (r_state == F_IDLE && i_start) begin
      r_data <= i_data;
      r_addr <= i_addr;
    end
  end

  always_comb begin
    w_next = r_state;
    w_wr   = 1'b0;
    o_ack  = 1'b0;
    o_fin  = 1'b0;
    unique case (r_state)
      F_IDLE:  if (i_start) w_next = F_WRITE;
      F_WRITE: begin
        w_wr   = 1'b1;
        w_next = F_ACK;
      end
      F_ACK: begin
        o_ack = 1'b1;
        if (i_abort) begin
          w_next = F_IDLE;
        end else if (!i_done) begin
          w_next = F_IDLE;
          o_fin  = 1'b1;
        end
      end
      default: w_next = F_IDLE;
    endcase
  end

  // Gate with rst so the write bus is quiet for the whole reset window
  assign o_we   = w_wr & rst;
  assign o_addr = o_we ? r_addr : '0;
  assign o_data = o_we ? r_data : '0;

endmodule

// File: rtl/ram_load_receiver.sv
// FM and weight RAM load receiver with weight refill requests.
// Define RAM_LOAD_TIMEOUT_EN to enable the handshake watchdog.
module ram_load_receiver
  import ram_load_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int WEIGHT_DEPTH   = 16
) (
  input logic                  clk,
  input logic                  rst,
  ram_load_receiver_if.slave   bus
);

  localparam int IW = WEIGHT_WRITE_ADDR_WIDTH;
  localparam logic [IW-1:0] IDX_LAST = IW'(WEIGHT_DEPTH - 1);

  w_state_e                    r_w_state;
  w_state_e                    w_w_next;
  logic [IW-1:0]               r_refill_idx;
  logic                        r_fm_loaded;
  logic                        r_w_loaded;
  logic                        r_refill_done;
  logic                        w_init_loaded;
  logic                        w_wt_start;
  logic                        w_refill_fin;
  logic                        w_update;
  logic                        w_fm_we, w_fm_ack, w_fm_fin;
  logic                        w_wt_we, w_wt_ack, w_wt_fin;
  logic                        w_fm_to, w_wt_to, w_err;
  logic [WRITE_ADDR_WIDTH-1:0] w_fm_addr;
  logic [FM_W-1:0]             w_fm_data;
  logic [WA_W-1:0]             w_wt_addr;
  logic [WT_W-1:0]             w_wt_data;

  load_rx_channel #(.DW(FM_W), .AW(WRITE_ADDR_WIDTH)) u_fm (
    .clk     (clk),
    .rst     (rst),
    .i_start (bus.init_fm_data_done),
    .i_done  (bus.init_fm_data_done),
    .i_abort (w_fm_to),
    .i_data  (bus.init_fm_data),
    .i_addr  (bus.write_fm_data_addr),
    .o_we    (w_fm_we),
    .o_ack   (w_fm_ack),
    .o_fin   (w_fm_fin),
    .o_addr  (w_fm_addr),
    .o_data  (w_fm_data)
  );

  load_rx_channel #(.DW(WT_W), .AW(WA_W)) u_wt (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_wt_start),
    .i_done  (bus.weight_data_done),
    .i_abort (w_wt_to),
    .i_data  (bus.weight_data),
    .i_addr  (bus.write_weight_data_addr),
    .o_we    (w_wt_we),
    .o_ack   (w_wt_ack),
    .o_fin   (w_wt_fin),
    .o_addr  (w_wt_addr),
    .o_data  (w_wt_data)
  );

  assign w_init_loaded = r_fm_loaded & r_w_loaded;

  always_comb begin
    w_w_next   = r_w_state;
    w_wt_start = 1'b0;
    unique case (r_w_state)
      W_IDLE: begin
        if (!r_w_loaded && bus.weight_data_done) begin
          w_wt_start = 1'b1;
          w_w_next   = W_WRITE;
        end else if (w_init_loaded && bus.weight_refill_req) begin
          w_w_next = W_REQ;
        end
      end
      W_WRITE:  w_w_next = W_ACK;
      W_ACK: begin
        if (w_wt_to || !bus.weight_data_done) w_w_next = W_IDLE;
      end
      W_REQ: begin
        if (w_wt_to) begin
          w_w_next = W_IDLE;
        end else if (bus.weight_data_done) begin
          w_wt_start = 1'b1;
          w_w_next   = W_RWRITE;
        end
      end
      W_RWRITE: w_w_next = W_RACK;
      W_RACK: begin
        if (w_wt_to || !bus.weight_data_done) w_w_next = W_IDLE;
      end
      default:  w_w_next = W_IDLE;
    endcase
  end

  assign w_refill_fin = (r_w_state == W_RACK) & w_wt_fin;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_w_state     <= W_IDLE;
      r_refill_idx  <= '0;
      r_fm_loaded   <= 1'b0;
      r_w_loaded    <= 1'b0;
      r_refill_done <= 1'b0;
    end else begin
      r_w_state     <= w_w_next;
      r_refill_done <= w_refill_fin;
      if (w_fm_fin) r_fm_loaded <= 1'b1;
      if (r_w_state == W_ACK && w_wt_fin) r_w_loaded <= 1'b1;
      if (w_refill_fin) begin
        r_refill_idx <= (r_refill_idx == IDX_LAST) ? '0
                        : r_refill_idx + 1'b1;
      end
    end
  end

`ifdef RAM_LOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_fm_cnt;
  logic [CW-1:0] r_wt_cnt;
  logic          r_err;
  logic          w_wt_wait;

  assign w_wt_wait = (r_w_state == W_REQ) | (r_w_state == W_ACK)
                   | (r_w_state == W_RACK);
  assign w_fm_to   = w_fm_ack & (r_fm_cnt == CNT_LAST);
  assign w_wt_to   = w_wt_wait & (r_wt_cnt == CNT_LAST);
  assign w_err     = r_err;

  // Every wait state is entered from a non-wait state, so the
  // counters are always back at zero when a new wait begins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fm_cnt <= '0;
      r_wt_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_fm_cnt <= (w_fm_ack && !w_fm_to) ? r_fm_cnt + 1'b1 : '0;
      r_wt_cnt <= (w_wt_wait && !w_wt_to) ? r_wt_cnt + 1'b1 : '0;
      if (w_fm_to || w_wt_to) r_err <= 1'b1;
    end
  end
`else
  assign w_fm_to = 1'b0;
  assign w_wt_to = 1'b0;
  assign w_err   = 1'b0;
`endif

  assign w_update = (r_w_state == W_REQ) | (r_w_state == W_RWRITE);

  assign bus.fm_ram_we              = w_fm_we;
  assign bus.fm_ram_addr            = w_fm_addr;
  assign bus.fm_ram_wdata           = w_fm_data;
  assign bus.init_fm_ram_ready      = w_fm_ack;
  assign bus.weight_ram_we          = {PARA_KERNEL{w_wt_we}};
  assign bus.weight_ram_addr        = w_wt_addr;
  assign bus.weight_ram_wdata       = w_wt_data;
  assign bus.init_weight_ram_ready  = w_wt_ack & (r_w_state == W_ACK);
  assign bus.update_weight_ram      = w_update;
  assign bus.update_weight_ram_addr = w_update ? rep_addr(r_refill_idx)
                                               : '0;
  assign bus.refill_done            = r_refill_done;
  assign bus.init_loaded            = w_init_loaded;
  assign bus.err_timeout            = w_err;

endmodule

// File: tb/tb_ram_load_receiver.sv
// Self-checking bench for ram_load_receiver (WEIGHT_DEPTH=2, TIMEOUT_CYCLES=8).
// Watchdog scenario runs only when RAM_LOAD_TIMEOUT_EN is defined.
module tb_ram_load_receiver;
  import ram_load_receiver_pkg::*;

  localparam int DEPTH = 2;
  localparam int TO    = 8;
  localparam int IW    = WEIGHT_WRITE_ADDR_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   m_idx = 0;

  ram_load_receiver_if bus ();

  ram_load_receiver #(.TIMEOUT_CYCLES(TO), .WEIGHT_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FM_W-1:0] rand_fm();
    logic [FM_W-1:0] v;
    for (int i = 0; i < FM_W; i += 32) v[i+:32] = $urandom;
    return v;
  endfunction

  function automatic logic [WT_W-1:0] rand_wt();
    logic [WT_W-1:0] v;
    for (int i = 0; i < WT_W; i += 32) v[i+:32] = $urandom;
    return v;
  endfunction

  function automatic logic [WA_W-1:0] exp_req_addr(input int idx);
    logic [IW-1:0] a;
    a = IW'(idx);
    return {PARA_KERNEL{a}};
  endfunction

  task automatic idle_inputs();
    bus.init_fm_data           = '0;
    bus.write_fm_data_addr     = '0;
    bus.init_fm_data_done      = 1'b0;
    bus.weight_data            = '0;
    bus.write_weight_data_addr = '0;
    bus.weight_data_done       = 1'b0;
    bus.weight_refill_req      = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    rst = 1'b1;
    m_idx = 0;
  endtask

  task automatic init_loads_quiet();
    bus.init_fm_data_done = 1'b1;
    bus.weight_data_done  = 1'b1;
    step(); step();
    bus.init_fm_data_done = 1'b0;
    bus.weight_data_done  = 1'b0;
    step();
  endtask

  task automatic refill_quiet();
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    bus.weight_data_done  = 1'b1;
    step(); step();
    bus.weight_data_done  = 1'b0;
    step();
    m_idx = (m_idx + 1) % DEPTH;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    bus.init_fm_data_done = 1'b1;
    bus.weight_data_done  = 1'b1;
    step(); step();
    total++;
    if ({bus.fm_ram_we, bus.weight_ram_we} !== '0) begin
      bad++;
      $display("FAIL reset_we got=%b want=0",
               {bus.fm_ram_we, bus.weight_ram_we});
    end
    total++;
    if ({bus.init_fm_ram_ready, bus.init_weight_ram_ready,
         bus.update_weight_ram, bus.refill_done,
         bus.init_loaded, bus.err_timeout} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {bus.init_fm_ram_ready, bus.init_weight_ram_ready,
                bus.update_weight_ram, bus.refill_done,
                bus.init_loaded, bus.err_timeout});
    end
    total++;
    if (bus.fm_ram_wdata !== '0 || bus.update_weight_ram_addr !== '0) begin
      bad++;
      $display("FAIL reset_buses got=%h/%h want=0",
               bus.fm_ram_wdata, bus.update_weight_ram_addr);
    end
    idle_inputs();
    rst = 1'b1;
    m_idx = 0;
    step();
    total++;
    if ({bus.fm_ram_we, bus.init_fm_ram_ready, bus.init_loaded} !== 3'b0) begin
      bad++;
      $display("FAIL post_reset_idle got=%b want=000",
               {bus.fm_ram_we, bus.init_fm_ram_ready, bus.init_loaded});
    end
  endtask

  task automatic test_fm_basic();
    logic [FM_W-1:0]             d;
    logic [WRITE_ADDR_WIDTH-1:0] a;
    d = {(PARA_X*PARA_Y){PAYLOAD_TEST_WORD}};
    bus.init_fm_data       = d;
    bus.write_fm_data_addr = '0;
    bus.init_fm_data_done  = 1'b1;
    step();
    total++;
    if (bus.fm_ram_we !== 1'b1 || bus.fm_ram_wdata !== d
        || bus.fm_ram_addr !== '0) begin
      bad++;
      $display("FAIL fm_write_c1 we=%b data=%h addr=%h want we=1 data=%h",
               bus.fm_ram_we, bus.fm_ram_wdata, bus.fm_ram_addr, d);
    end
    step();
    total++;
    if (bus.init_fm_ram_ready !== 1'b1 || bus.fm_ram_we !== 1'b0) begin
      bad++;
      $display("FAIL fm_ready_c2 rdy=%b we=%b want rdy=1 we=0",
               bus.init_fm_ram_ready, bus.fm_ram_we);
    end
    bus.init_fm_data_done = 1'b0;
    step();
    total++;
    if (bus.init_fm_ram_ready !== 1'b0) begin
      bad++;
      $display("FAIL fm_ready_drop got=%b want=0", bus.init_fm_ram_ready);
    end
    total++;
    if (bus.init_loaded !== 1'b0) begin
      bad++;
      $display("FAIL fm_only_loaded got=%b want=0", bus.init_loaded);
    end
    d = rand_fm();
    a = WRITE_ADDR_WIDTH'($urandom_range(1, 255));
    bus.init_fm_data       = d;
    bus.write_fm_data_addr = a;
    bus.init_fm_data_done  = 1'b1;
    step();
    bus.init_fm_data = ~d;
    total++;
    if (bus.fm_ram_wdata !== d || bus.fm_ram_addr !== a) begin
      bad++;
      $display("FAIL fm_rand_write data=%h addr=%h want %h/%h",
               bus.fm_ram_wdata, bus.fm_ram_addr, d, a);
    end
    step();
    bus.init_fm_data_done = 1'b0;
    step();
  endtask

  task automatic test_concurrent();
    logic [FM_W-1:0]             fd;
    logic [WRITE_ADDR_WIDTH-1:0] fa;
    logic [WT_W-1:0]             wd;
    logic [WA_W-1:0]             wa;
    apply_reset();
    fd = rand_fm();
    fa = WRITE_ADDR_WIDTH'($urandom);
    wd = rand_wt();
    wa = WA_W'($urandom);
    bus.init_fm_data           = fd;
    bus.write_fm_data_addr     = fa;
    bus.weight_data            = wd;
    bus.write_weight_data_addr = wa;
    bus.init_fm_data_done      = 1'b1;
    bus.weight_data_done       = 1'b1;
    step();
    total++;
    if (bus.fm_ram_we !== 1'b1 || bus.weight_ram_we !== {PARA_KERNEL{1'b1}}) begin
      bad++;
      $display("FAIL both_we fm=%b wt=%b want 1/all-ones",
               bus.fm_ram_we, bus.weight_ram_we);
    end
    total++;
    if (bus.fm_ram_wdata !== fd || bus.weight_ram_wdata !== wd
        || bus.weight_ram_addr !== wa || bus.fm_ram_addr !== fa) begin
      bad++;
      $display("FAIL both_data fm=%h wa=%h want fm=%h wa=%h",
               bus.fm_ram_wdata, bus.weight_ram_addr, fd, wa);
    end
    step();
    total++;
    if (bus.init_fm_ram_ready !== 1'b1 || bus.init_weight_ram_ready !== 1'b1
        || bus.init_loaded !== 1'b0) begin
      bad++;
      $display("FAIL both_ready fm=%b wt=%b loaded=%b want 1/1/0",
               bus.init_fm_ram_ready, bus.init_weight_ram_ready,
               bus.init_loaded);
    end
    bus.init_fm_data_done = 1'b0;
    bus.weight_data_done  = 1'b0;
    step();
    total++;
    if (bus.init_loaded !== 1'b1) begin
      bad++;
      $display("FAIL init_loaded got=%b want=1", bus.init_loaded);
    end
  endtask

  task automatic test_refill_seq();
    logic [WT_W-1:0] wd;
    logic [WA_W-1:0] wa;
    for (int k = 0; k < 3; k++) begin
      bus.weight_refill_req = 1'b1;
      step();
      bus.weight_refill_req = 1'b0;
      total++;
      if (bus.update_weight_ram !== 1'b1
          || bus.update_weight_ram_addr !== exp_req_addr(m_idx)) begin
        bad++;
        $display("FAIL refill_req k=%0d upd=%b addr=%h want 1/%h", k,
                 bus.update_weight_ram, bus.update_weight_ram_addr,
                 exp_req_addr(m_idx));
      end
      repeat ($urandom_range(0, 3)) step();
      wd = rand_wt();
      wa = WA_W'($urandom);
      bus.weight_data            = wd;
      bus.write_weight_data_addr = wa;
      bus.weight_data_done       = 1'b1;
      step();
      total++;
      if (bus.weight_ram_we !== {PARA_KERNEL{1'b1}} || bus.weight_ram_addr !== wa
          || bus.weight_ram_wdata !== wd) begin
        bad++;
        $display("FAIL refill_write k=%0d we=%b addr=%h want all-ones/%h",
                 k, bus.weight_ram_we, bus.weight_ram_addr, wa);
      end
      step();
      total++;
      if (bus.update_weight_ram !== 1'b0 || bus.weight_ram_we !== '0) begin
        bad++;
        $display("FAIL refill_rack k=%0d upd=%b we=%b want 0/0",
                 k, bus.update_weight_ram, bus.weight_ram_we);
      end
      bus.weight_data_done = 1'b0;
      step();
      total++;
      if (bus.refill_done !== 1'b1) begin
        bad++;
        $display("FAIL refill_done k=%0d got=%b want=1", k, bus.refill_done);
      end
      m_idx = (m_idx + 1) % DEPTH;
      step();
      total++;
      if (bus.refill_done !== 1'b0) begin
        bad++;
        $display("FAIL refill_pulse k=%0d got=%b want=0", k, bus.refill_done);
      end
    end
  endtask

  task automatic test_ignore_rules();
    int hits;
    hits = 0;
    bus.weight_data_done = 1'b1;
    repeat (3) begin
      step();
      if (bus.weight_ram_we !== '0 || bus.update_weight_ram !== 1'b0) hits++;
    end
    bus.weight_data_done = 1'b0;
    step();
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL done_without_req got=%0d want=0 activity", hits);
    end
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    bus.weight_data_done  = 1'b1;
    step(); step();
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    bus.weight_data_done  = 1'b0;
    step();
    total++;
    if (bus.refill_done !== 1'b1) begin
      bad++;
      $display("FAIL rack_req_done got=%b want=1", bus.refill_done);
    end
    m_idx = (m_idx + 1) % DEPTH;
    hits = 0;
    repeat (4) begin
      step();
      if (bus.update_weight_ram !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL rack_req_dropped got=%0d want=0 updates", hits);
    end
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    total++;
    if (bus.update_weight_ram_addr !== exp_req_addr(m_idx)) begin
      bad++;
      $display("FAIL idx_after_rack got=%h want=%h",
               bus.update_weight_ram_addr, exp_req_addr(m_idx));
    end
    bus.weight_data_done = 1'b1;
    step(); step();
    bus.weight_data_done = 1'b0;
    step();
    m_idx = (m_idx + 1) % DEPTH;
    step();
  endtask

  task automatic test_reset_mid_req();
    while (m_idx != 1) refill_quiet();
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    total++;
    if (bus.update_weight_ram !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_req got=%b want=1", bus.update_weight_ram);
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.update_weight_ram !== 1'b0 || bus.init_loaded !== 1'b0) begin
      bad++;
      $display("FAIL mid_req_reset upd=%b loaded=%b want 0/0",
               bus.update_weight_ram, bus.init_loaded);
    end
    rst = 1'b1;
    m_idx = 0;
    step();
    init_loads_quiet();
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    total++;
    if (bus.update_weight_ram_addr !== exp_req_addr(m_idx)) begin
      bad++;
      $display("FAIL idx_after_reset got=%h want=%h",
               bus.update_weight_ram_addr, exp_req_addr(m_idx));
    end
    bus.weight_data_done = 1'b1;
    step(); step();
    bus.weight_data_done = 1'b0;
    step();
    m_idx = (m_idx + 1) % DEPTH;
    step();
  endtask

  task automatic test_random();
    logic [FM_W-1:0]             fd;
    logic [WRITE_ADDR_WIDTH-1:0] fa;
    logic [WT_W-1:0]             wd;
    logic [WA_W-1:0]             wa;
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        fd = rand_fm();
        fa = WRITE_ADDR_WIDTH'($urandom);
        bus.init_fm_data       = fd;
        bus.write_fm_data_addr = fa;
        bus.init_fm_data_done  = 1'b1;
        step();
        bus.init_fm_data = rand_fm();
        total++;
        if (bus.fm_ram_we !== 1'b1 || bus.fm_ram_wdata !== fd
            || bus.fm_ram_addr !== fa) begin
          bad++;
          $display("FAIL rnd_fm n=%0d data=%h addr=%h want %h/%h", n,
                   bus.fm_ram_wdata, bus.fm_ram_addr, fd, fa);
        end
        repeat ($urandom_range(1, 3)) step();
        total++;
        if (bus.init_fm_ram_ready !== 1'b1) begin
          bad++;
          $display("FAIL rnd_fm_hold n=%0d got=%b want=1", n,
                   bus.init_fm_ram_ready);
        end
        bus.init_fm_data_done = 1'b0;
        step();
      end else begin
        bus.weight_refill_req = 1'b1;
        step();
        bus.weight_refill_req = 1'b0;
        total++;
        if (bus.update_weight_ram_addr !== exp_req_addr(m_idx)) begin
          bad++;
          $display("FAIL rnd_req n=%0d got=%h want=%h", n,
                   bus.update_weight_ram_addr, exp_req_addr(m_idx));
        end
        repeat ($urandom_range(0, 4)) step();
        wd = rand_wt();
        wa = WA_W'($urandom);
        bus.weight_data            = wd;
        bus.write_weight_data_addr = wa;
        bus.weight_data_done       = 1'b1;
        step();
        total++;
        if (bus.weight_ram_wdata !== wd || bus.weight_ram_addr !== wa) begin
          bad++;
          $display("FAIL rnd_wt n=%0d addr=%h want=%h", n,
                   bus.weight_ram_addr, wa);
        end
        repeat ($urandom_range(1, 3)) step();
        bus.weight_data_done = 1'b0;
        step();
        total++;
        if (bus.refill_done !== 1'b1) begin
          bad++;
          $display("FAIL rnd_done n=%0d got=%b want=1", n, bus.refill_done);
        end
        m_idx = (m_idx + 1) % DEPTH;
        step();
      end
    end
  endtask

`ifdef RAM_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    repeat (TO - 1) step();
    total++;
    if (bus.err_timeout !== 1'b0 || bus.update_weight_ram !== 1'b1) begin
      bad++;
      $display("FAIL to_early err=%b upd=%b want 0/1",
               bus.err_timeout, bus.update_weight_ram);
    end
    step();
    total++;
    if (bus.err_timeout !== 1'b1 || bus.update_weight_ram !== 1'b0) begin
      bad++;
      $display("FAIL to_fire err=%b upd=%b want 1/0",
               bus.err_timeout, bus.update_weight_ram);
    end
    bus.weight_refill_req = 1'b1;
    step();
    bus.weight_refill_req = 1'b0;
    total++;
    if (bus.update_weight_ram !== 1'b1
        || bus.update_weight_ram_addr !== exp_req_addr(m_idx)) begin
      bad++;
      $display("FAIL to_idle_again upd=%b want=1", bus.update_weight_ram);
    end
    apply_reset();
    total++;
    if (bus.err_timeout !== 1'b0) begin
      bad++;
      $display("FAIL to_reset got=%b want=0", bus.err_timeout);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_fm_basic();
    test_concurrent();
    test_refill_seq();
    test_ignore_rules();
    test_reset_mid_req();
    test_random();
`ifdef RAM_LOAD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
